// File: rtl/param_sync_fifo.sv
// Single-clock FIFO of arbitrary depth with programmable almost-flags, standard/FWFT read,
// synchronous flush and sticky overflow/underflow flags.
module param_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_w_en,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_r_en,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_rd_valid,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_almost_empty,
    output logic                       o_almost_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH-1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     w_ptr, r_ptr;
    logic [CW-1:0]     count;
    logic              wr_acc, rd_acc;

    assign o_count        = count;
    assign o_empty        = (count == '0);
    assign o_full         = (count == DEPTH_C);
    assign o_almost_empty = (count <= AE_C);
    assign o_almost_full  = (AF_LEVEL != 0) && (count >= AF_C);
    assign wr_acc         = i_w_en & ~o_full;
    assign rd_acc         = i_r_en & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_flush) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            // explicit wrap so non-power-of-2 depths work
            if (wr_acc) w_ptr <= (w_ptr == LAST) ? '0 : w_ptr + PW'(1);
            if (rd_acc) r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (i_w_en && o_full)  o_overflow  <= 1'b1;
            if (i_r_en && o_empty) o_underflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && wr_acc) mem[w_ptr] <= i_data;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_W-1:0] data_q;
            logic              vld_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else if (i_flush) begin
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc) data_q <= mem[r_ptr];
                end
            end
            assign o_data     = data_q;
            assign o_rd_valid = vld_q;
        end else begin : g_fwft
            // head is presented combinationally; zero while empty so reset reads 0
            assign o_data     = o_empty ? '0 : mem[r_ptr];
            assign o_rd_valid = ~o_empty;
        end
    endgenerate
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: three FIFO configurations share one stimulus stream; each test checks
// the instance it targets.
module tb_param_sync_fifo;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_flush = 1'b0, i_w_en = 1'b0, i_r_en = 1'b0;
    logic [7:0] i_data = '0;

    logic [7:0] d8_data, d5_data, df_data;
    logic       d8_vld, d8_emp, d8_ful, d8_ae, d8_af, d8_ovf, d8_unf;
    logic       d5_vld, d5_emp, d5_ful, d5_ae, d5_af, d5_ovf, d5_unf;
    logic       df_vld, df_emp, df_ful, df_ae, df_af, df_ovf, df_unf;
    logic [3:0] d8_cnt;
    logic [2:0] d5_cnt, df_cnt;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_d8 (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_w_en(i_w_en), .i_data(i_data),
        .i_r_en(i_r_en), .o_data(d8_data), .o_rd_valid(d8_vld), .o_empty(d8_emp), .o_full(d8_ful),
        .o_almost_empty(d8_ae), .o_almost_full(d8_af), .o_count(d8_cnt),
        .o_overflow(d8_ovf), .o_underflow(d8_unf));

    param_sync_fifo #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_w_en(i_w_en), .i_data(i_data),
        .i_r_en(i_r_en), .o_data(d5_data), .o_rd_valid(d5_vld), .o_empty(d5_emp), .o_full(d5_ful),
        .o_almost_empty(d5_ae), .o_almost_full(d5_af), .o_count(d5_cnt),
        .o_overflow(d5_ovf), .o_underflow(d5_unf));

    param_sync_fifo #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_df (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_w_en(i_w_en), .i_data(i_data),
        .i_r_en(i_r_en), .o_data(df_data), .o_rd_valid(df_vld), .o_empty(df_emp), .o_full(df_ful),
        .o_almost_empty(df_ae), .o_almost_full(df_af), .o_count(df_cnt),
        .o_overflow(df_ovf), .o_underflow(df_unf));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; outputs sampled 1 time unit later
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        i_w_en = 1'b1; i_data = d;
        step();
        i_w_en = 1'b0;
    endtask

    task automatic pop();
        i_r_en = 1'b1;
        step();
        i_r_en = 1'b0;
    endtask

    task automatic both(input logic [7:0] d);
        i_w_en = 1'b1; i_r_en = 1'b1; i_data = d;
        step();
        i_w_en = 1'b0; i_r_en = 1'b0;
    endtask

    task automatic flush();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
    endtask

    initial begin
        #12 i_rst = 1'b0;
        step();

        // reset state
        check("rst_empty", d8_emp, 1);
        check("rst_full", d8_ful, 0);
        check("rst_ae", d8_ae, 1);
        check("rst_af", d8_af, 0);
        check("rst_count", d8_cnt, 0);
        check("rst_data", d8_data, 0);
        check("rst_vld", d8_vld, 0);
        check("rst_ovf", d8_ovf, 0);
        check("rst_unf", d8_unf, 0);
        check("rst_f_vld", df_vld, 0);

        // 1: fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            push(8'h11 + 8'(i));
            check("t1_cnt", d8_cnt, i + 1);
            check("t1_af", d8_af, (i + 1 >= 6));
            check("t1_ae", d8_ae, (i + 1 <= 2));
        end
        check("t1_full", d8_ful, 1);
        push(8'hFF);
        check("t1_ovf", d8_ovf, 1);
        check("t1_cnt_ovf", d8_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            pop();
            check("t1_rdata", d8_data, 8'h11 + i);
            check("t1_rvld", d8_vld, 1);
        end
        step();
        check("t1_vld_drop", d8_vld, 0);
        check("t1_hold", d8_data, 8'h18);
        check("t1_empty", d8_emp, 1);
        check("t1_ovf_sticky", d8_ovf, 1);

        // 2: underflow, cleared by flush
        pop();
        check("t2_unf", d8_unf, 1);
        check("t2_cnt", d8_cnt, 0);
        check("t2_vld", d8_vld, 0);
        flush();
        check("t2_unf_clr", d8_unf, 0);
        check("t2_ovf_clr", d8_ovf, 0);

        // 3: depth 5, steady count 2 across pointer wrap
        push(8'h00);
        push(8'h01);
        for (int k = 0; k < 10; k++) begin
            both(8'(k + 2));
            check("t3_data", d5_data, k);
            check("t3_vld", d5_vld, 1);
            check("t3_cnt", d5_cnt, 2);
        end
        pop();
        check("t3_tail0", d5_data, 8'h0A);
        pop();
        check("t3_tail1", d5_data, 8'h0B);
        check("t3_empty", d5_emp, 1);
        check("t3_ovf", d5_ovf, 0);
        check("t3_unf", d5_unf, 0);

        // 4: simultaneous at full and at count 3
        flush();
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        both(8'h99);
        check("t4_full_head", d8_data, 8'h20);
        check("t4_full_cnt", d8_cnt, 7);
        check("t4_full_ovf", d8_ovf, 1);
        for (int i = 0; i < 4; i++) pop();
        check("t4_cnt3", d8_cnt, 3);
        both(8'h55);
        check("t4_mid_head", d8_data, 8'h25);
        check("t4_mid_cnt", d8_cnt, 3);
        pop();
        check("t4_d0", d8_data, 8'h26);
        pop();
        check("t4_d1", d8_data, 8'h27);
        pop();
        check("t4_d2", d8_data, 8'h55);
        check("t4_empty", d8_emp, 1);

        // 5: FWFT
        flush();
        check("t5_pre_vld", df_vld, 0);
        push(8'hA5);
        check("t5_data", df_data, 8'hA5);
        check("t5_vld", df_vld, 1);
        pop();
        check("t5_empty", df_emp, 1);
        check("t5_vld_off", df_vld, 0);
        push(8'h01);
        push(8'h02);
        check("t5_head", df_data, 8'h01);
        pop();
        check("t5_next", df_data, 8'h02);

        // 6: flush beats write, then async reset mid-burst
        flush();
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        check("t6_cnt4", d8_cnt, 4);
        i_w_en = 1'b1; i_data = 8'h77;
        flush();
        check("t6_fl_cnt", d8_cnt, 0);
        check("t6_fl_empty", d8_emp, 1);
        for (int i = 0; i < 9; i++) push(8'h30 + 8'(i));
        pop();
        check("t6_pre_data", d8_data, 8'h30);
        check("t6_pre_ovf", d8_ovf, 1);
        i_r_en = 1'b1;
        #2 i_rst = 1'b1;
        #1;
        check("t6_rst_cnt", d8_cnt, 0);
        check("t6_rst_empty", d8_emp, 1);
        check("t6_rst_full", d8_ful, 0);
        check("t6_rst_af", d8_af, 0);
        check("t6_rst_ae", d8_ae, 1);
        check("t6_rst_data", d8_data, 0);
        check("t6_rst_vld", d8_vld, 0);
        check("t6_rst_ovf", d8_ovf, 0);
        i_r_en = 1'b0;
        #3 i_rst = 1'b0;
        step();
        check("t6_post_empty", d8_emp, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
